// File: rtl/fc_pkg.sv
// Shared types and constants for the fully connected layer output path.
package fc_pkg;

    localparam int ACTIV_BITS_DEFAULT = 8;
    localparam int OVR_BITS           = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } fc_ser_state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running arg-max over a stream of signed elements; lowest index wins ties.
// Latency: max_value/max_index are combinational and already include the current sample.
// Backpressure: none; the caller asserts sample only on an accepted element.
module argmax_tracker
    import fc_pkg::*;
#(
    parameter int ACTIV_BITS = ACTIV_BITS_DEFAULT,
    parameter int IDX_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample,
    input  logic                  first,
    input  logic [ACTIV_BITS-1:0] value,
    input  logic [IDX_BITS-1:0]   index,
    output logic [ACTIV_BITS-1:0] max_value,
    output logic [IDX_BITS-1:0]   max_index
);

    logic [ACTIV_BITS-1:0] cur_value;
    logic [IDX_BITS-1:0]   cur_index;
    logic                  take;

    // Showing the post-sample max lets the caller latch the final winner on the
    // same edge as the last element handshake.
    always_comb begin
        take      = sample && (first || ($signed(value) > $signed(cur_value)));
        max_value = take ? value : cur_value;
        max_index = take ? index : cur_index;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_value <= '0;
            cur_index <= '0;
        end else if (sample) begin
            cur_value <= max_value;
            cur_index <= max_index;
        end
    end

endmodule

// File: rtl/fc_output_serializer.sv
// Captures one activation vector and streams it element-wise, reporting the arg-max once per vector.
// Latency: element 0 one cycle after capture; argmax_valid one cycle after the last element handshake.
// Backpressure: elem_ready stalls the stream; vectors arriving while busy are dropped and counted.
module fc_output_serializer
    import fc_pkg::*;
#(
    parameter int VEC_SIZE   = 64,
    parameter int ACTIV_BITS = ACTIV_BITS_DEFAULT,
    parameter int IDX_BITS   = $clog2(VEC_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [VEC_SIZE*ACTIV_BITS-1:0] vec_data,
    input  logic                           vec_valid,
    output logic                           vec_ready,
    output logic [ACTIV_BITS-1:0]          elem_data,
    output logic [IDX_BITS-1:0]            elem_index,
    output logic                           elem_last,
    output logic                           elem_valid,
    input  logic                           elem_ready,
    output logic [IDX_BITS-1:0]            argmax_index,
    output logic [ACTIV_BITS-1:0]          argmax_value,
    output logic                           argmax_valid,
    output logic [OVR_BITS-1:0]            overrun_count
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(VEC_SIZE - 1);

    fc_ser_state_t         state;
    logic [ACTIV_BITS-1:0] cap [VEC_SIZE];
    logic [IDX_BITS-1:0]   nxt_idx;
    logic                  elem_fire;
    logic [ACTIV_BITS-1:0] trk_value;
    logic [IDX_BITS-1:0]   trk_index;

    assign nxt_idx   = elem_index + 1'b1;
    assign elem_fire = (state == STREAM) && elem_ready;

    argmax_tracker #(
        .ACTIV_BITS (ACTIV_BITS),
        .IDX_BITS   (IDX_BITS)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .sample    (elem_fire),
        .first     (elem_index == '0),
        .value     (elem_data),
        .index     (elem_index),
        .max_value (trk_value),
        .max_index (trk_index)
    );

    // elem_index doubles as the stream counter; all outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            vec_ready    <= 1'b1;
            elem_valid   <= 1'b0;
            elem_last    <= 1'b0;
            elem_data    <= '0;
            elem_index   <= '0;
            argmax_valid <= 1'b0;
            argmax_index <= '0;
            argmax_value <= '0;
            for (int i = 0; i < VEC_SIZE; i++) cap[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (vec_valid) begin
                        for (int i = 0; i < VEC_SIZE; i++)
                            cap[i] <= vec_data[i*ACTIV_BITS +: ACTIV_BITS];
                        state      <= STREAM;
                        vec_ready  <= 1'b0;
                        elem_valid <= 1'b1;
                        elem_data  <= vec_data[ACTIV_BITS-1:0];
                        elem_index <= '0;
                        elem_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (elem_ready) begin
                        if (elem_index == LAST_IDX) begin
                            state        <= DONE;
                            elem_valid   <= 1'b0;
                            elem_last    <= 1'b0;
                            argmax_valid <= 1'b1;
                            argmax_index <= trk_index;
                            argmax_value <= trk_value;
                        end else begin
                            elem_index <= nxt_idx;
                            elem_data  <= cap[nxt_idx];
                            elem_last  <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    argmax_valid <= 1'b0;
                    vec_ready    <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    vec_ready <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_count <= '0;
        end else if (vec_valid && !vec_ready && (overrun_count != '1)) begin
            overrun_count <= overrun_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fc_output_serializer.sv
// Directed bench for fc_output_serializer with VEC_SIZE=4.
module tb_fc_output_serializer;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int IB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*AB-1:0] vec_data;
    logic          vec_valid;
    logic          vec_ready;
    logic [AB-1:0] elem_data;
    logic [IB-1:0] elem_index;
    logic          elem_last;
    logic          elem_valid;
    logic          elem_ready;
    logic [IB-1:0] argmax_index;
    logic [AB-1:0] argmax_value;
    logic          argmax_valid;
    logic [7:0]    overrun_count;

    int checks = 0;
    int errors = 0;

    fc_output_serializer #(.VEC_SIZE(N), .ACTIV_BITS(AB)) dut (
        .clk           (clk),
        .rst           (rst),
        .vec_data      (vec_data),
        .vec_valid     (vec_valid),
        .vec_ready     (vec_ready),
        .elem_data     (elem_data),
        .elem_index    (elem_index),
        .elem_last     (elem_last),
        .elem_valid    (elem_valid),
        .elem_ready    (elem_ready),
        .argmax_index  (argmax_index),
        .argmax_value  (argmax_value),
        .argmax_valid  (argmax_valid),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*AB-1:0] vec;
        logic [IB-1:0]   idx;
        logic [AB-1:0]   val;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AB-1:0] elem_of(input logic [N*AB-1:0] v, input int k);
        return v[k*AB +: AB];
    endfunction

    function automatic logic [N*AB-1:0] pack(input logic [7:0] e0, input logic [7:0] e1,
                                             input logic [7:0] e2, input logic [7:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        vec_valid = 1'b0;
        elem_ready = 1'b1;
        vec_data = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vec_ready"},    32'(vec_ready), 32'd1);
        chk({tag, "_elem_valid"},   32'(elem_valid), 32'd0);
        chk({tag, "_elem_last"},    32'(elem_last), 32'd0);
        chk({tag, "_elem_data"},    32'(elem_data), 32'd0);
        chk({tag, "_elem_index"},   32'(elem_index), 32'd0);
        chk({tag, "_argmax_valid"}, 32'(argmax_valid), 32'd0);
        chk({tag, "_argmax_index"}, 32'(argmax_index), 32'd0);
        chk({tag, "_argmax_value"}, 32'(argmax_value), 32'd0);
        chk({tag, "_overrun"},      32'(overrun_count), 32'd0);
    endtask

    // Streams one vector with elem_ready high; optionally strobes vec_valid while
    // presenting element inj_k and/or in the DONE cycle.
    task automatic run_vec(input logic [N*AB-1:0] v, input logic [IB-1:0] eidx,
                           input logic [AB-1:0] eval, input int inj_k, input bit inj_done,
                           input logic [7:0] exp_ovr);
        chk("accept_vec_ready", 32'(vec_ready), 32'd1);
        elem_ready = 1'b1;
        vec_data = v;
        vec_valid = 1'b1;
        step();
        for (int k = 0; k < N; k++) begin
            chk("elem_valid", 32'(elem_valid), 32'd1);
            chk("elem_data",  32'(elem_data), 32'(elem_of(v, k)));
            chk("elem_index", 32'(elem_index), 32'(k));
            chk("elem_last",  32'(elem_last), 32'(k == N - 1));
            chk("stream_vec_ready", 32'(vec_ready), 32'd0);
            chk("stream_argmax_valid", 32'(argmax_valid), 32'd0);
            vec_valid = (k == inj_k);
            vec_data = ~v;
            step();
        end
        chk("done_argmax_valid", 32'(argmax_valid), 32'd1);
        chk("done_argmax_index", 32'(argmax_index), 32'(eidx));
        chk("done_argmax_value", 32'(argmax_value), 32'(eval));
        chk("done_elem_valid",   32'(elem_valid), 32'd0);
        chk("done_vec_ready",    32'(vec_ready), 32'd0);
        vec_valid = inj_done;
        step();
        vec_valid = 1'b0;
        chk("idle_vec_ready",    32'(vec_ready), 32'd1);
        chk("idle_argmax_valid", 32'(argmax_valid), 32'd0);
        chk("idle_argmax_index", 32'(argmax_index), 32'(eidx));
        chk("idle_argmax_value", 32'(argmax_value), 32'(eval));
        chk("idle_overrun",      32'(overrun_count), 32'(exp_ovr));
    endtask

    initial begin
        bit [15:0] pat;
        int        k;
        int        cyc;
        logic [N*AB-1:0] v;

        tbl[0] = '{pack(8'd3, 8'hFF, 8'd7, 8'd2),       2'd2, 8'd7};
        tbl[1] = '{pack(8'hFB, 8'hFE, 8'hFE, 8'hF8),    2'd1, 8'hFE};
        tbl[2] = '{pack(8'h7F, 8'h80, 8'h00, 8'h01),    2'd0, 8'h7F};
        tbl[3] = '{pack(8'd1, 8'd1, 8'd1, 8'd1),        2'd0, 8'd1};
        tbl[4] = '{pack(8'h80, 8'h80, 8'h80, 8'h7F),    2'd3, 8'h7F};

        rst = 1'b1;
        vec_valid = 1'b0;
        elem_ready = 1'b1;
        vec_data = '0;
        #1;
        chk_reset_outputs("reset");
        step();
        rst = 1'b0;
        step();
        chk_reset_outputs("post_reset");

        for (int i = 0; i < 5; i++)
            run_vec(tbl[i].vec, tbl[i].idx, tbl[i].val, -1, 1'b0, 8'd0);

        // Backpressure: 1,0,0,1,0,1,1,...
        v = tbl[0].vec;
        pat = 16'b1111_1111_1110_1001;
        vec_data = v;
        vec_valid = 1'b1;
        elem_ready = pat[0];
        step();
        vec_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < N && cyc < 40) begin
            chk("bp_elem_valid", 32'(elem_valid), 32'd1);
            chk("bp_elem_data",  32'(elem_data), 32'(elem_of(v, k)));
            chk("bp_elem_index", 32'(elem_index), 32'(k));
            chk("bp_elem_last",  32'(elem_last), 32'(k == N - 1));
            elem_ready = pat[cyc % 16];
            step();
            if (elem_ready) k++;
            cyc++;
        end
        chk("bp_completed", 32'(k), 32'(N));
        chk("bp_argmax_valid", 32'(argmax_valid), 32'd1);
        chk("bp_argmax_index", 32'(argmax_index), 32'd2);
        chk("bp_argmax_value", 32'(argmax_value), 32'd7);
        elem_ready = 1'b1;
        step();
        chk("bp_vec_ready", 32'(vec_ready), 32'd1);

        // Overrun during STREAM (cycle T+2) and in DONE.
        do_reset();
        run_vec(tbl[0].vec, 2'd2, 8'd7, 1, 1'b1, 8'd2);
        run_vec(tbl[1].vec, 2'd1, 8'hFE, -1, 1'b0, 8'd2);

        // Overrun saturation with the stream stalled.
        do_reset();
        v = tbl[2].vec;
        vec_data = v;
        vec_valid = 1'b1;
        elem_ready = 1'b0;
        step();
        for (int i = 0; i < 300; i++) begin
            vec_data = ~v;
            step();
            if (i == 99) chk("sat_ovr_100", 32'(overrun_count), 32'd100);
            if (i == 253) chk("sat_ovr_254", 32'(overrun_count), 32'd254);
        end
        vec_valid = 1'b0;
        step();
        chk("sat_ovr_255",    32'(overrun_count), 32'd255);
        chk("sat_elem_index", 32'(elem_index), 32'd0);
        chk("sat_elem_data",  32'(elem_data), 32'h7F);
        chk("sat_elem_valid", 32'(elem_valid), 32'd1);

        // Reset mid-stream after index 2 is presented.
        do_reset();
        v = tbl[0].vec;
        vec_data = v;
        vec_valid = 1'b1;
        elem_ready = 1'b1;
        step();
        vec_valid = 1'b0;
        step();
        step();
        chk("mid_elem_index", 32'(elem_index), 32'd2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mid_no_argmax", 32'(argmax_valid), 32'd0);
            chk("mid_no_elem",   32'(elem_valid), 32'd0);
        end
        run_vec(tbl[1].vec, 2'd1, 8'hFE, -1, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
